// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// Package C: core-wide types shared between the fetch, decode and the queue
// that sits between them.
//
// Contents:
//   XLEN          architectural register / address width
//   FQ_DEPTH      number of entries in the fetch -> decode queue
//   bp_t          branch prediction attached to a fetched instruction
//   fetch_data_t  one fetched packet: PC, instruction word, prediction
// -----------------------------------------------------------------------------
package C;

    localparam int XLEN = 32;

    // The core top instantiates fetch_queue #(.DEPTH(FQ_DEPTH)).
    localparam int FQ_DEPTH = 4;

    // Prediction made by the fetch stage for this instruction.
    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
    } bp_t;

    // Packet travelling from fetch to decode.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     data;
        bp_t             bp;
    } fetch_data_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue: registered instruction FIFO between fetch and decode.
//
// Decouples instruction-cache response timing from decode back-pressure and
// drops everything it holds when the pipeline is flushed.  There is no
// combinational path from the decode side (dec_o_ready) to the fetch side
// (fetch_i_ready).
//
// Parameters:
//   DEPTH          number of entries, power of 2, at least 2
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rstn           synchronous active-low reset
//   flush_i        discard all contents this cycle (highest priority)
//   fetch_i        packet from fetch
//   fetch_i_valid  fetch_i holds a valid packet
//   fetch_i_ready  queue can accept a packet (not full)
//   dec_o          head packet towards decode
//   dec_o_valid    dec_o is valid (not empty and no flush this cycle)
//   dec_o_ready    decode consumes dec_o
//   count_o        current occupancy, 0 .. DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
    import C::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush_i,
    input  fetch_data_t              fetch_i,
    input  logic                     fetch_i_valid,
    output logic                     fetch_i_ready,
    output fetch_data_t              dec_o,
    output logic                     dec_o_valid,
    input  logic                     dec_o_ready,
    output logic [$clog2(DEPTH):0]   count_o
);

    // Index width and pointer width; the extra pointer bit is the wrap bit
    // that tells a full queue apart from an empty one.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fetch_data_t       mem [DEPTH];
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_q;

    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    // Status decode from the two pointers.  Full means the indices match but
    // the writer has lapped the reader once.
    always_comb begin
        empty = (rd_ptr_q == wr_ptr_q);
        full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) &&
                (rd_ptr_q[AW] != wr_ptr_q[AW]);
    end

    // Handshakes.  Ready towards fetch only looks at fullness so that decode
    // stalls never ripple combinationally into fetch.  A flush hides the head
    // from decode and blocks any write in the same cycle.
    always_comb begin
        fetch_i_ready = !full;
        dec_o_valid   = !empty && !flush_i;
        push          = fetch_i_valid && fetch_i_ready && !flush_i;
        pop           = dec_o_valid && dec_o_ready;
    end

    // Output side: head entry and occupancy.  Modulo arithmetic on the
    // pointers gives the count directly, including across wrap-around.
    always_comb begin
        dec_o   = mem[rd_ptr_q[AW-1:0]];
        count_o = wr_ptr_q - rd_ptr_q;
    end

    // Pointer update.  Reset and flush both simply empty the queue by
    // zeroing the pointers; push and pop are independent otherwise.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage.  The array is never cleared; only the pointers say which
    // entries hold live packets.  Writes are held off during reset.
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_ptr_q[AW-1:0]] <= fetch_i;
        end
    end

endmodule
